// File: rtl/psum_pkg.sv
// Shared types and default widths for the partial-sum accumulator.
package psum_pkg;

    localparam int PSUM_MUL_W = 16;
    localparam int PSUM_ACC_W = 24;
    localparam int PSUM_LEN_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } psum_state_e;

endpackage

// File: rtl/psum_sat_add.sv
// ACC_W-bit signed adder with overflow flag and optional clamp to the signed range.
module psum_sat_add #(
    parameter int ACC_W  = 24,
    parameter bit SAT_EN = 1'b0
) (
    input  logic signed [ACC_W-1:0] i_a,
    input  logic signed [ACC_W-1:0] i_b,
    output logic signed [ACC_W-1:0] o_sum,
    output logic                    o_ovf
);

    logic [ACC_W:0] wide_s;

    // One guard bit exposes signed overflow; its value is the sign of the true sum.
    always_comb begin
        wide_s = {i_a[ACC_W-1], i_a} + {i_b[ACC_W-1], i_b};
        o_ovf  = wide_s[ACC_W] ^ wide_s[ACC_W-1];
        if (SAT_EN && o_ovf) begin
            if (wide_s[ACC_W]) begin
                o_sum = {1'b1, {(ACC_W-1){1'b0}}};
            end else begin
                o_sum = {1'b0, {(ACC_W-1){1'b1}}};
            end
        end else begin
            o_sum = wide_s[ACC_W-1:0];
        end
    end

endmodule

// File: rtl/psum_acc.sv
// Accumulates a counted burst of signed products and hands the sum downstream.
// Define PSUM_ACC_SAT_EN for saturating adds and a live o_sat flag.
module psum_acc
    import psum_pkg::*;
#(
    parameter int MUL_W = PSUM_MUL_W,
    parameter int ACC_W = PSUM_ACC_W,
    parameter int LEN_W = PSUM_LEN_W
) (
    input  logic                    i_clk,
    input  logic                    i_resetn,
    input  logic                    i_start,
    input  logic [LEN_W-1:0]        i_len,
    input  logic                    i_valid,
    input  logic signed [MUL_W-1:0] i_mul,
    output logic                    o_in_ready,
    output logic                    o_out_valid,
    input  logic                    i_out_ready,
    output logic signed [ACC_W-1:0] o_psum,
    output logic                    o_sat
);

`ifdef PSUM_ACC_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    psum_state_e             state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [LEN_W-1:0]        cnt_q, cnt_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic                    sat_q, sat_d;
    logic                    in_rdy_q, in_rdy_d;
    logic                    out_vld_q, out_vld_d;
    logic signed [ACC_W-1:0] mul_ext_s;
    logic signed [ACC_W-1:0] add_sum_s;
    logic                    add_ovf_s;
    logic                    beat_s;

    assign mul_ext_s = ACC_W'(i_mul);
    assign beat_s    = i_valid & in_rdy_q;

    psum_sat_add #(
        .ACC_W  (ACC_W),
        .SAT_EN (SAT_EN)
    ) u_add (
        .i_a   (acc_q),
        .i_b   (mul_ext_s),
        .o_sum (add_sum_s),
        .o_ovf (add_ovf_s)
    );

    // Next-state, datapath and handshake flags; handshake flags follow the next state.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        sat_d   = sat_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    acc_d   = {ACC_W{1'b0}};
                    cnt_d   = {LEN_W{1'b0}};
                    sat_d   = 1'b0;
                    len_d   = i_len;
                    state_d = (i_len == {LEN_W{1'b0}}) ? ST_DONE : ST_ACC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACC: begin
                if (beat_s) begin
                    acc_d = add_sum_s;
                    cnt_d = cnt_q + LEN_W'(1);
                    sat_d = sat_q | (SAT_EN & add_ovf_s);
                    if (cnt_q == len_q - LEN_W'(1)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ACC;
                    end
                end else begin
                    state_d = ST_ACC;
                end
            end
            ST_DONE: begin
                if (i_out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        in_rdy_d  = (state_d == ST_ACC);
        out_vld_d = (state_d == ST_DONE);
    end

    // State and datapath registers; reset discards any in-flight sum.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            state_q   <= ST_IDLE;
            acc_q     <= {ACC_W{1'b0}};
            cnt_q     <= {LEN_W{1'b0}};
            len_q     <= {LEN_W{1'b0}};
            sat_q     <= 1'b0;
            in_rdy_q  <= 1'b0;
            out_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            sat_q     <= sat_d;
            in_rdy_q  <= in_rdy_d;
            out_vld_q <= out_vld_d;
        end
    end

    assign o_in_ready  = in_rdy_q;
    assign o_out_valid = out_vld_q;
    assign o_psum      = acc_q;
    assign o_sat       = sat_q;

endmodule

// File: tb/tb_psum_acc.sv
// Scoreboard bench for psum_acc (ACC_W=16); follows PSUM_ACC_SAT_EN like the DUT.
module tb_psum_acc;

    localparam int MUL_W = 16;
    localparam int ACC_W = 16;
    localparam int LEN_W = 8;
    localparam longint MAXV  = (64'sd1 <<< (ACC_W - 1)) - 64'sd1;
    localparam longint MINV  = -MAXV - 64'sd1;
    localparam longint RANGE = MAXV - MINV + 64'sd1;
`ifdef PSUM_ACC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        logic [ACC_W-1:0] psum;
        logic             sat;
    } exp_t;

    logic                    i_clk = 1'b0;
    logic                    i_resetn = 1'b1;
    logic                    i_start = 1'b0;
    logic [LEN_W-1:0]        i_len = '0;
    logic                    i_valid = 1'b0;
    logic signed [MUL_W-1:0] i_mul = '0;
    logic                    i_out_ready = 1'b0;
    logic                    o_in_ready;
    logic                    o_out_valid;
    logic [ACC_W-1:0]        o_psum;
    logic                    o_sat;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    psum_acc #(.MUL_W(MUL_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
        .i_clk       (i_clk),
        .i_resetn    (i_resetn),
        .i_start     (i_start),
        .i_len       (i_len),
        .i_valid     (i_valid),
        .i_mul       (i_mul),
        .o_in_ready  (o_in_ready),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_psum      (o_psum),
        .o_sat       (o_sat)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input longint act, input longint req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Reference: running sum of the products, clamped or wrapped after every add.
    function automatic exp_t model(input int b[$]);
        longint acc;
        exp_t   e;
        acc   = 0;
        e.sat = 1'b0;
        foreach (b[i]) begin
            acc += b[i];
            if (SAT) begin
                if (acc > MAXV) begin
                    acc = MAXV;
                    e.sat = 1'b1;
                end else if (acc < MINV) begin
                    acc = MINV;
                    e.sat = 1'b1;
                end
            end else begin
                acc = (acc - MINV) % RANGE;
                if (acc < 0) acc += RANGE;
                acc += MINV;
            end
        end
        e.psum = acc[ACC_W-1:0];
        return e;
    endfunction

    task automatic step();
        @(posedge i_clk);
        #2;
    endtask

    task automatic run_job(input int b[$], input int gaps[$], input int hold);
        int w;
        sb.push_back(model(b));
        i_start = 1'b1;
        i_len   = LEN_W'(b.size());
        step();
        i_start = 1'b0;
        i_len   = LEN_W'($urandom);
        foreach (b[k]) begin
            repeat (gaps[k]) begin
                i_valid = 1'b0;
                i_mul   = MUL_W'($urandom);
                step();
            end
            i_valid = 1'b1;
            i_mul   = MUL_W'(b[k]);
            w = 0;
            while (!o_in_ready && w < 20) begin
                step();
                w++;
            end
            chk("in_ready_on_beat", longint'(o_in_ready), 1);
            step();
        end
        i_valid = 1'b0;
        chk("out_valid_latency", longint'(o_out_valid), 1);
        chk("in_ready_in_done", longint'(o_in_ready), 0);
        repeat (hold) begin
            i_start = 1'b1;
            i_len   = LEN_W'($urandom_range(1, 5));
            i_valid = 1'b1;
            i_mul   = MUL_W'($urandom);
            step();
        end
        i_start     = 1'b0;
        i_valid     = 1'b0;
        i_out_ready = 1'b1;
        step();
        i_out_ready = 1'b0;
        chk("back_to_idle", longint'(o_out_valid), 0);
    endtask

    // Monitor: compares at each result handshake and checks hold stability while stalled.
    exp_t             mon_e;
    logic             have_prev = 1'b0;
    logic [ACC_W-1:0] prev_psum;
    logic             prev_sat;
    initial begin
        forever begin
            @(negedge i_clk);
            if (i_resetn && o_out_valid) begin
                if (have_prev) begin
                    chk("hold_psum", longint'(o_psum), longint'(prev_psum));
                    chk("hold_sat", longint'(o_sat), longint'(prev_sat));
                end
                if (i_out_ready) begin
                    have_prev = 1'b0;
                    if (sb.size() == 0) begin
                        chk("unexpected_result", 1, 0);
                    end else begin
                        mon_e = sb.pop_front();
                        chk("psum", longint'(signed'(o_psum)), longint'(signed'(mon_e.psum)));
                        chk("sat", longint'(o_sat), longint'(mon_e.sat));
                    end
                end else begin
                    have_prev = 1'b1;
                    prev_psum = o_psum;
                    prev_sat  = o_sat;
                end
            end else begin
                have_prev = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int b[$];
        int g[$];
        int len;
        #3;
        i_resetn = 1'b0;
        #1;
        chk("rst_psum", longint'(o_psum), 0);
        chk("rst_sat", longint'(o_sat), 0);
        chk("rst_in_ready", longint'(o_in_ready), 0);
        chk("rst_out_valid", longint'(o_out_valid), 0);
        step();
        step();
        i_resetn = 1'b1;
        step();

        b = '{960, -8};          g = '{0, 0};       run_job(b, g, 0);
        b = '{1234, -5000, 77};  g = '{0, 1, 1};    run_job(b, g, 0);
        b = '{-321};             g = '{0};          run_job(b, g, 5);
        b = '{32767, 1};         g = '{0, 0};       run_job(b, g, 1);
        b = '{-32768, -1};       g = '{1, 0};       run_job(b, g, 0);
        b = '{};                 g = '{};           run_job(b, g, 2);

        // Reset mid-accumulation after one of four beats.
        i_start = 1'b1;
        i_len   = LEN_W'(4);
        step();
        i_start = 1'b0;
        i_valid = 1'b1;
        i_mul   = MUL_W'(100);
        step();
        i_valid = 1'b0;
        #1;
        i_resetn = 1'b0;
        #1;
        chk("midrst_psum", longint'(o_psum), 0);
        chk("midrst_sat", longint'(o_sat), 0);
        chk("midrst_in_ready", longint'(o_in_ready), 0);
        chk("midrst_out_valid", longint'(o_out_valid), 0);
        step();
        i_resetn = 1'b1;
        step();
        b = '{-4}; g = '{0}; run_job(b, g, 0);

        for (int j = 0; j < 40; j++) begin
            b.delete();
            g.delete();
            len = $urandom_range(0, 6);
            for (int k = 0; k < len; k++) begin
                b.push_back(int'($signed(MUL_W'($urandom))));
                g.push_back($urandom_range(0, 2));
            end
            run_job(b, g, $urandom_range(0, 3));
        end

        step();
        chk("results_drained", longint'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/psum_acc.md
PSUM_ACC -- requirements
Module: psum_acc

Interface
REQ-001 SHALL have parameter MUL_W, default 16: width of signed product input from the upstream multiplier.
REQ-002 SHALL have parameter ACC_W, default 24: width of signed accumulator and result; ACC_W >= MUL_W.
REQ-003 SHALL have parameter LEN_W, default 8: width of the term-count input.
REQ-004 SHALL have port i_clk  input  1  rising-edge clock.
REQ-005 SHALL have port i_resetn  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port i_start  input  1  one-cycle request to begin a new accumulation.
REQ-007 SHALL have port i_len  input  LEN_W  unsigned number of products to sum, sampled with i_start.
REQ-008 SHALL have port i_valid  input  1  product beat valid.
REQ-009 SHALL have port i_mul  input  MUL_W  signed product.
REQ-010 SHALL have port o_in_ready  output  1  block accepts a product this cycle.
REQ-011 SHALL have port o_out_valid  output  1  result valid.
REQ-012 SHALL have port i_out_ready  input  1  downstream accepts result.
REQ-013 SHALL have port o_psum  output  ACC_W  signed accumulated sum.
REQ-014 SHALL have port o_sat  output  1  result was clamped (saturation build only).

Function
REQ-015 SHALL implement FSM states IDLE, ACC, DONE.
REQ-016 IDLE: o_in_ready=0, o_out_valid=0; i_start=1 with i_len>0 clears acc and count, latches i_len, goes to ACC next cycle.
REQ-017 IDLE with i_start=1 and i_len=0 SHALL go to DONE with o_psum=0.
REQ-018 ACC: o_in_ready=1; a beat is accepted only when i_valid=1 and o_in_ready=1; i_valid alone without acceptance changes nothing.
REQ-019 Each accepted beat SHALL add sign-extended i_mul to acc and increment count.
REQ-020 Beat with count == len-1 SHALL be last: FSM enters DONE next cycle with o_psum holding final sum (latency 1 cycle after last beat).
REQ-021 DONE: o_in_ready=0, o_out_valid=1; o_psum and o_sat SHALL stay stable until i_out_ready=1.
REQ-022 DONE with i_out_ready=1 SHALL return to IDLE next cycle, o_out_valid deasserting.
REQ-023 i_start outside IDLE SHALL be ignored; i_len changes outside IDLE SHALL have no effect.
REQ-024 Without saturation, sum SHALL wrap modulo 2^ACC_W (two's complement).

Reset
REQ-025 Asynchronous assertion of i_resetn=0 SHALL force state IDLE, acc=0, count=0, o_psum=0, o_sat=0, o_in_ready=0, o_out_valid=0, including mid-ACC or mid-DONE; in-flight sum is discarded.
REQ-026 Operation SHALL resume on the first rising i_clk edge after i_resetn deasserts.

Configuration
REQ-027 Macro PSUM_ACC_SAT_EN defined: each add SHALL clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; o_sat SHALL set on any clamp and clear on accepted i_start.
REQ-028 Macro PSUM_ACC_SAT_EN undefined: wrapping add per REQ-024; o_sat SHALL be tied 0.

Structure
REQ-029 Package psum_pkg SHALL hold the FSM state enum and default width constants (MUL_W, ACC_W, LEN_W).
REQ-030 Sub-module psum_sat_add SHALL implement the ACC_W signed add with optional clamp and overflow flag; psum_acc instantiates it once.

Verification
REQ-031 start len=2, beats 960 then -8 -> o_out_valid 1 cycle after 2nd beat, o_psum=952, o_sat=0.
REQ-032 start len=3, i_valid gapped (beat, idle, beat, idle, beat) -> o_psum = exact sum, count ignores idle cycles.
REQ-033 len=1 result held with i_out_ready=0 for 5 cycles -> o_psum/o_out_valid stable; i_start during DONE ignored; ready=1 -> IDLE next cycle.
REQ-034 ACC_W=16, len=2, beats 32767, 1 -> with PSUM_ACC_SAT_EN o_psum=32767, o_sat=1; without o_psum=-32768, o_sat=0.
REQ-035 i_resetn pulsed low mid-ACC after 1 of 4 beats -> all outputs 0 immediately; new start len=1 beat -4 -> o_psum=-4.
REQ-036 start with len=0 -> DONE next cycle, o_psum=0, no beat accepted.
